// File: rtl/irq_nmi_controller.sv
`default_nettype none
// ============================================================================
//  Module      : irq_nmi_controller
//  Description : Trap sequencer for one NMI source and four prioritised,
//                maskable external IRQs.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_nmi_controller #(
    parameter logic [31:0] NMI_VEC  = 32'h0000_0100,
    parameter logic [31:0] IRQ_BASE = 32'h0000_0200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tmrF,
    input  logic [3:0]  ext_irq,
    input  logic        irq_en,
    input  logic        trap_ack,
    input  logic [31:0] pc_in,
    input  logic        mret,
    output logic        trap_req,
    output logic [31:0] trap_vec,
    output logic [2:0]  cause,
    output logic [31:0] epc,
    output logic        in_handler,
    output logic        nmi_ovf
);

    localparam logic [2:0] C_CAUSE_NMI = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SERV = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_nmi_pend, w_nmi_pend_nxt, w_nmi_ovf_nxt, w_nmi_clr;
    logic        w_src_valid;
    logic [2:0]  w_src_cause;
    logic [31:0] w_src_vec;
    logic        w_trap_req_nxt, w_in_handler_nxt;
    logic [2:0]  w_cause_nxt;
    logic [31:0] w_trap_vec_nxt, w_epc_nxt;

    // Source selection: NMI (pending or arriving this cycle) beats every IRQ.
    always_comb begin
        w_src_valid = 1'b0;
        w_src_cause = 3'd0;
        if (r_nmi_pend || tmrF) begin
            w_src_valid = 1'b1;
            w_src_cause = C_CAUSE_NMI;
        end else if (irq_en) begin
            w_src_valid = 1'b1;
            casez (ext_irq)
                4'b???1: w_src_cause = 3'd0;
                4'b??10: w_src_cause = 3'd1;
                4'b?100: w_src_cause = 3'd2;
                4'b1000: w_src_cause = 3'd3;
                default: w_src_valid = 1'b0;
            endcase
        end
        w_src_vec = (w_src_cause == C_CAUSE_NMI) ? NMI_VEC
                  : IRQ_BASE + {27'd0, w_src_cause, 2'b00};
    end

    // A new tmrF pulse always wins over a simultaneous acknowledge of the NMI.
    always_comb begin
        w_nmi_clr      = (r_state == S_REQ) && trap_ack && (cause == C_CAUSE_NMI);
        w_nmi_pend_nxt = tmrF || (r_nmi_pend && !w_nmi_clr);
        w_nmi_ovf_nxt  = nmi_ovf || (tmrF && r_nmi_pend && !w_nmi_clr);
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_trap_req_nxt   = trap_req;
        w_trap_vec_nxt   = trap_vec;
        w_cause_nxt      = cause;
        w_epc_nxt        = epc;
        w_in_handler_nxt = in_handler;
        case (r_state)
            S_IDLE: begin
                if (w_src_valid) begin
                    w_state_nxt    = S_REQ;
                    w_trap_req_nxt = 1'b1;
                    w_cause_nxt    = w_src_cause;
                    w_trap_vec_nxt = w_src_vec;
                end
            end
            S_REQ: begin
                if (trap_ack) begin
                    w_state_nxt      = S_SERV;
                    w_trap_req_nxt   = 1'b0;
                    w_epc_nxt        = pc_in;
                    w_in_handler_nxt = 1'b1;
                end else if (w_src_valid) begin
                    w_cause_nxt    = w_src_cause;
                    w_trap_vec_nxt = w_src_vec;
                end else begin
                    w_state_nxt    = S_IDLE;
                    w_trap_req_nxt = 1'b0;
                end
            end
            S_SERV: begin
                if (mret) begin
                    w_state_nxt      = S_IDLE;
                    w_in_handler_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_trap_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_nmi_pend <= 1'b0;
            nmi_ovf    <= 1'b0;
            trap_req   <= 1'b0;
            trap_vec   <= 32'd0;
            cause      <= 3'd0;
            epc        <= 32'd0;
            in_handler <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_nmi_pend <= w_nmi_pend_nxt;
            nmi_ovf    <= w_nmi_ovf_nxt;
            trap_req   <= w_trap_req_nxt;
            trap_vec   <= w_trap_vec_nxt;
            cause      <= w_cause_nxt;
            epc        <= w_epc_nxt;
            in_handler <= w_in_handler_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/irq_nmi_controller.md
IRQ_NMI_CONTROLLER -- requirements
Module: irq_nmi_controller

Interface
REQ-001 Parameter NMI_VEC, 32'h0000_0100, trap target address for the non-maskable timer interrupt.
REQ-002 Parameter IRQ_BASE, 32'h0000_0200, base address for external IRQ vectors; IRQ n vectors to IRQ_BASE + 4*n.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 tmrF  input  1  one-cycle NMI pulse from the timer block.
REQ-006 ext_irq  input  4  level-sensitive external IRQs; bit 0 has highest priority.
REQ-007 irq_en  input  1  global maskable-IRQ enable; NMI ignores it.
REQ-008 trap_ack  input  1  core accepts the pending trap at an instruction boundary; meaningful only while trap_req=1.
REQ-009 pc_in  input  32  PC of the instruction the core will resume at; sampled on trap_ack.
REQ-010 mret  input  1  one-cycle pulse; handler return.
REQ-011 trap_req  output  1  trap request to the core.
REQ-012 trap_vec  output  32  target address of the requested trap.
REQ-013 cause  output  3  4 = NMI, 0..3 = ext_irq index.
REQ-014 epc  output  32  saved return PC.
REQ-015 in_handler  output  1  high while a handler is being serviced.
REQ-016 nmi_ovf  output  1  sticky NMI-overrun flag.

Function
REQ-017 The block SHALL implement a three-state FSM: IDLE, REQ, SERV; all outputs are registered.
REQ-018 The block SHALL set nmi_pend on any cycle with tmrF=1 and clear it only on trap_ack of an NMI.
REQ-019 If tmrF=1 and nmi_pend=1 and the same cycle does not clear nmi_pend, the block SHALL set nmi_ovf; nmi_ovf clears only on reset.
REQ-020 If trap_ack clears nmi_pend in the same cycle as tmrF=1, the block SHALL keep nmi_pend=1 (set wins) and SHALL NOT set nmi_ovf.
REQ-021 In IDLE, if nmi_pend=1 or tmrF=1, the block SHALL go to REQ with cause=4. Otherwise, if irq_en=1 and ext_irq!=0, it SHALL go to REQ with cause equal to the lowest set ext_irq index. trap_req SHALL rise one cycle after the triggering input.
REQ-022 In REQ with trap_ack=0, the block SHALL re-select the source every cycle using the same priority. An NMI arrival upgrades cause and trap_vec to NMI. If no source remains, including irq_en dropping, the block SHALL return to IDLE and deassert trap_req.
REQ-023 trap_vec SHALL equal NMI_VEC when cause=4, and IRQ_BASE + 4*cause otherwise, using a 32-bit add with no overflow check.
REQ-024 In REQ with trap_ack=1, the block SHALL latch epc<=pc_in, keep cause and trap_vec, deassert trap_req, set in_handler, and enter SERV.
REQ-025 In SERV, the block SHALL accept no new trap; tmrF SHALL still set nmi_pend and nmi_ovf per REQ-018..020.
REQ-026 In SERV, mret=1 SHALL return the block to IDLE and clear in_handler; epc and cause SHALL hold until the next trap_ack.
REQ-027 A pending source on mret SHALL produce trap_req exactly one cycle after the IDLE entry cycle evaluates it.
REQ-028 The block SHALL ignore mret outside SERV and trap_ack outside REQ.

Reset
REQ-029 While rst=0, the block SHALL asynchronously force IDLE, nmi_pend=0, nmi_ovf=0, trap_req=0, trap_vec=0, cause=0, epc=0, and in_handler=0.
REQ-030 Reset asserted mid-REQ or mid-SERV SHALL discard the pending or in-service trap; after release, only new inputs cause requests.

Verification
REQ-031 irq_en=1, ext_irq=4'b1010 -> next cycle trap_req=1, cause=1, trap_vec=32'h0000_0204; trap_ack with pc_in=32'h0000_0040 -> epc=32'h40, in_handler=1.
REQ-032 In REQ with cause=3, pulse tmrF before ack -> cause=4, trap_vec=32'h100; ack -> nmi_pend cleared, nmi_ovf=0.
REQ-033 irq_en=0, ext_irq=4'b1111 -> trap_req stays 0; a tmrF pulse -> trap_req=1, cause=4.
REQ-034 In SERV, two tmrF pulses 3 cycles apart -> nmi_ovf=1; mret -> IDLE, then trap_req=1 with cause=4 one cycle later.
REQ-035 In REQ with cause=2, drop ext_irq to 0 -> trap_req=0 next cycle, state IDLE, no epc change.
REQ-036 Assert rst=0 mid-SERV, asynchronously with no clock edge -> all outputs 0 immediately; release with no inputs -> trap_req stays 0.
